spi_cmd_decoder: RTL and testbench

Command decoder and register bank sitting directly downstream of the SPI slave unit, in the SYS_CLK domain. It consumes each 16-bit word the SPI unit captures (data_from_mosi), qualified by the end of the strob_LOAD level. It decodes the word as a NOP/READ/WRITE/STATUS command and updates an internal register bank. It drives the response word (data_in_SPI) that the SPI unit shifts out on MISO during the next frame.

---
 rtl/spi_cmd_pkg.sv | 13 +
 rtl/cmd_reg_bank.sv | 29 ++
 rtl/spi_cmd_decoder.sv | 100 ++++++++++
 tb/tb_spi_cmd_decoder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared types, field positions and status-word helper for the SPI command decoder
package spi_cmd_pkg;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_READ = 2'b01, OP_WRITE = 2'b10, OP_STATUS = 2'b11} op_t;
  typedef enum logic {IDLE = 1'b0, WAIT_DATA = 1'b1} state_t;
  localparam logic [7:0] STATUS_SIG = 8'hA5;
  localparam int OP_HI = 15;
  localparam int OP_LO = 14;
  localparam int ADDR_HI = 3;
  localparam int ADDR_LO = 0;
  function automatic logic [15:0] status_word(input logic pend, input logic err, input logic [5:0] fcnt);
    return {STATUS_SIG, pend, err, fcnt};
  endfunction
endpackage

// File: rtl/cmd_reg_bank.sv
// cmd_reg_bank: N_REGS x 16 register storage with one write port, combinational read port and flat view
module cmd_reg_bank
  import spi_cmd_pkg::*;
#(
  parameter int N_REGS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [3:0]            waddr,
  input  logic [15:0]           wdata,
  input  logic [3:0]            raddr,
  output logic [15:0]           rdata,
  output logic [16*N_REGS-1:0]  regs_flat
);
  logic [15:0] regs_q [N_REGS];
  always_ff @(posedge clk)
    for (int i = 0; i < N_REGS; i++)
      if (rst) regs_q[i] <= '0;
      else if (we && waddr == 4'(i)) regs_q[i] <= wdata;
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_REGS; i++)
      if (raddr == 4'(i)) rdata = regs_q[i];
  end
  for (genvar g = 0; g < N_REGS; g++) begin : g_flat
    assign regs_flat[16*g +: 16] = regs_q[g];
  end
endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: decodes SPI frames into NOP/READ/WRITE/STATUS on a register bank.
// Optional WRITE data-frame timeout enabled by defining SPI_CMD_TIMEOUT_EN.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int N_REGS      = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  SYS_CLK,
  input  logic                  all_clear,
  input  logic                  strob_LOAD,
  input  logic [15:0]           data_from_mosi,
  output logic [15:0]           data_in_SPI,
  output logic [16*N_REGS-1:0]  regs_flat,
  output logic                  wr_stb,
  output logic [3:0]            wr_addr
);
  if (N_REGS < 1 || N_REGS > 16 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("spi_cmd_decoder: N_REGS must be 1..16 and TIMEOUT_CYC at least 2");
  end
  state_t      state_q, state_d;
  logic        strob_q, err_q, err_d, wr_stb_q, we, fe, tmo, cmd_ok, lat_ok;
  logic [5:0]  fcnt_q, fcnt_d;
  logic [15:0] resp_q, resp_d, rd_data;
  logic [3:0]  addr_q, addr_d, wr_addr_q, wr_addr_d, cmd_addr;
  op_t         op;
  assign fe       = strob_q & ~strob_LOAD;
  assign op       = op_t'(data_from_mosi[OP_HI:OP_LO]);
  assign cmd_addr = data_from_mosi[ADDR_HI:ADDR_LO];
  assign cmd_ok   = {1'b0, cmd_addr} < 5'(N_REGS);
  assign lat_ok   = {1'b0, addr_q} < 5'(N_REGS);
  assign we       = fe && state_q == WAIT_DATA && lat_ok;
`ifdef SPI_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tmo_q;
  always_ff @(posedge SYS_CLK)
    tmo_q <= (all_clear || state_q != WAIT_DATA) ? '0 : tmo_q + 1'b1;
  assign tmo = state_q == WAIT_DATA && tmo_q == TW'(TIMEOUT_CYC - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    fcnt_d    = fcnt_q;
    resp_d    = resp_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    if (fe && state_q == WAIT_DATA) begin
      fcnt_d    = fcnt_q + 6'd1;
      state_d   = IDLE;
      err_d     = err_q | ~lat_ok;
      wr_addr_d = lat_ok ? addr_q : wr_addr_q;
      resp_d    = status_word(1'b0, err_d, fcnt_d);
    end else if (fe) begin
      fcnt_d  = fcnt_q + 6'd1;
      state_d = op == OP_WRITE ? WAIT_DATA : IDLE;
      addr_d  = op == OP_WRITE ? cmd_addr : addr_q;
      err_d   = op == OP_STATUS ? 1'b0 : (op == OP_READ && !cmd_ok) ? 1'b1 : err_q;
      resp_d  = op == OP_READ ? (cmd_ok ? rd_data : 16'h0000) : status_word(op == OP_WRITE, err_q, fcnt_d);
    end else if (tmo) begin
      state_d = IDLE;
      err_d   = 1'b1;
      resp_d  = status_word(1'b0, 1'b1, fcnt_q);
    end
  end
  always_ff @(posedge SYS_CLK)
    if (all_clear) begin
      state_q   <= IDLE;
      strob_q   <= 1'b0;
      err_q     <= 1'b0;
      fcnt_q    <= '0;
      resp_q    <= {STATUS_SIG, 8'h00};
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_stb_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      strob_q   <= strob_LOAD;
      err_q     <= err_d;
      fcnt_q    <= fcnt_d;
      resp_q    <= resp_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      wr_stb_q  <= we;
    end
  assign data_in_SPI = resp_q;
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  cmd_reg_bank #(.N_REGS(N_REGS)) u_bank (
    .clk       (SYS_CLK),
    .rst       (all_clear),
    .we        (we),
    .waddr     (addr_q),
    .wdata     (data_from_mosi),
    .raddr     (cmd_addr),
    .rdata     (rd_data),
    .regs_flat (regs_flat)
  );
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: directed vector table, reset/timeout sequences and randomized frames vs a frame-level model
module tb_spi_cmd_decoder;
  localparam int NR = 8;
  logic clk = 1'b0, rst = 1'b1, strob = 1'b0;
  logic [15:0] mosi = '0;
  logic [15:0] resp;
  logic [16*NR-1:0] regs_flat;
  logic wr_stb;
  logic [3:0] wr_addr;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  spi_cmd_decoder #(.N_REGS(NR), .TIMEOUT_CYC(16)) dut (
    .SYS_CLK(clk), .all_clear(rst), .strob_LOAD(strob), .data_from_mosi(mosi),
    .data_in_SPI(resp), .regs_flat(regs_flat), .wr_stb(wr_stb), .wr_addr(wr_addr)
  );
  logic [15:0] m_regs [16];
  bit m_pend, m_err;
  int m_fcnt;
  int m_wa;
  typedef struct { logic [15:0] w; logic [15:0] r; bit s; logic [3:0] a; } vec_t;
  vec_t v [15];
  logic [15:0] r, er;
  logic [3:0] a, ea;
  bit s, sa, es;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] m_stat();
    return {8'hA5, m_pend, m_err, 6'(m_fcnt)};
  endfunction
  function automatic void mdl_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_pend = 0; m_err = 0; m_fcnt = 0; m_wa = 0;
  endfunction
  function automatic void mdl(input logic [15:0] w, output logic [15:0] rr, output bit ss, output logic [3:0] aa);
    int ad;
    ad = int'(w[3:0]);
    ss = 0; aa = '0;
    m_fcnt = (m_fcnt + 1) % 64;
    if (m_pend) begin
      m_pend = 0;
      if (m_wa < NR) begin m_regs[m_wa] = w; ss = 1; aa = 4'(m_wa); end
      else m_err = 1;
      rr = m_stat();
    end else if (w[15:14] == 2'd1) begin
      if (ad < NR) rr = m_regs[ad];
      else begin rr = 16'h0000; m_err = 1; end
    end else if (w[15:14] == 2'd2) begin
      m_wa = ad; m_pend = 1; rr = m_stat();
    end else begin
      rr = m_stat();
      if (w[15:14] == 2'd3) m_err = 0;
    end
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; strob = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_reset();
  endtask
  task automatic frame(input logic [15:0] w, input int hi, output logic [15:0] rr, output bit ss, output logic [3:0] aa, output bit sa_o);
    logic [15:0] r0;
    @(negedge clk);
    r0 = resp;
    strob = 1'b1;
    repeat (hi) @(negedge clk);
    chk("stable while strob high", resp, r0);
    strob = 1'b0; mosi = w;
    @(negedge clk);
    rr = resp; ss = wr_stb; aa = wr_addr;
    @(negedge clk);
    sa_o = wr_stb;
  endtask
  initial begin
    v[0]  = '{16'h8003, 16'hA581, 0, 4'd0};
    v[1]  = '{16'h1234, 16'hA502, 1, 4'd3};
    v[2]  = '{16'h4003, 16'h1234, 0, 4'd0};
    v[3]  = '{16'h400A, 16'h0000, 0, 4'd0};
    v[4]  = '{16'hC000, 16'hA545, 0, 4'd0};
    v[5]  = '{16'hC000, 16'hA506, 0, 4'd0};
    v[6]  = '{16'h800C, 16'hA587, 0, 4'd0};
    v[7]  = '{16'hBEEF, 16'hA548, 0, 4'd0};
    v[8]  = '{16'h0000, 16'hA549, 0, 4'd0};
    v[9]  = '{16'hC000, 16'hA54A, 0, 4'd0};
    v[10] = '{16'h8007, 16'hA58B, 0, 4'd0};
    v[11] = '{16'hFFFF, 16'hA50C, 1, 4'd7};
    v[12] = '{16'h4007, 16'hFFFF, 0, 4'd0};
    v[13] = '{16'h4000, 16'h0000, 0, 4'd0};
    v[14] = '{16'h0000, 16'hA50F, 0, 4'd0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset resp", resp, 32'hA500);
    chk("reset regs", 32'(regs_flat == '0), 32'd1);
    chk("reset wr_stb", wr_stb, 0);
    chk("reset wr_addr", wr_addr, 0);
    for (int i = 0; i < 15; i++) begin
      frame(v[i].w, 2, r, s, a, sa);
      chk($sformatf("vec%0d resp", i), r, v[i].r);
      chk($sformatf("vec%0d wr_stb", i), s, v[i].s);
      if (v[i].s) begin
        chk($sformatf("vec%0d wr_addr", i), a, v[i].a);
        chk($sformatf("vec%0d wr_stb one cycle", i), sa, 0);
      end
    end
    chk("reg3", regs_flat[16*3 +: 16], 32'h1234);
    chk("reg7", regs_flat[16*7 +: 16], 32'hFFFF);
    chk("reg0", regs_flat[15:0], 32'h0000);
    do_reset();
    frame(16'h8001, 2, r, s, a, sa);
    chk("pending write resp", r, 32'hA581);
`ifdef SPI_CMD_TIMEOUT_EN
    repeat (14) @(negedge clk);
    chk("before timeout", resp, 32'hA581);
    @(negedge clk);
    chk("timeout status", resp, 32'hA541);
    chk("timeout bank", 32'(regs_flat == '0), 32'd1);
    frame(16'h00AA, 2, r, s, a, sa);
    chk("after timeout nop", r, 32'hA542);
    chk("after timeout no write", s, 0);
`else
    repeat (40) @(negedge clk);
    chk("wait persists", resp, 32'hA581);
    frame(16'h00AA, 2, r, s, a, sa);
    chk("late data resp", r, 32'hA502);
    chk("late data wr_stb", s, 1);
    chk("late data wr_addr", a, 1);
    chk("late data reg1", regs_flat[31:16], 32'h00AA);
`endif
    do_reset();
    frame(16'h8002, 2, r, s, a, sa);
    chk("cmd before reset", r, 32'hA581);
    do_reset();
    frame(16'h1234, 2, r, s, a, sa);
    chk("post-reset decoded as cmd", r, 32'hA501);
    chk("post-reset no write", s, 0);
    chk("post-reset bank", 32'(regs_flat == '0), 32'd1);
    do_reset();
    @(negedge clk); strob = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b1;
    @(negedge clk); strob = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("in-flight frame dropped", resp, 32'hA500);
    frame(16'h0000, 2, r, s, a, sa);
    chk("first nop after in-flight reset", r, 32'hA501);
    do_reset();
    for (int i = 1; i <= 64; i++) begin
      frame(16'h0000, 1, r, s, a, sa);
      if (i == 63) chk("nop 63", r, 32'hA53F);
      if (i == 64) chk("nop 64 wrap", r, 32'hA500);
    end
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      w[3:0] = 4'($urandom_range(0, 11));
      frame(w, $urandom_range(1, 4), r, s, a, sa);
      mdl(w, er, es, ea);
      chk($sformatf("rnd%0d resp w=%h", i, w), r, er);
      chk($sformatf("rnd%0d wr_stb", i), s, es);
      if (es) chk($sformatf("rnd%0d wr_addr", i), a, ea);
    end
    for (int i = 0; i < NR; i++) chk($sformatf("rnd final reg%0d", i), regs_flat[16*i +: 16], m_regs[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
